// File: rtl/monitor_bus_initiator_if.sv
// Signal bundle between a burst command source, the read/write byte streams and the
// monitor bus, as seen by monitor_bus_initiator (master) and its environment (slave).
interface monitor_bus_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  rd_data;
    logic [15:0] bus_address;
    logic        bus_write;
    logic [7:0]  bus_wdata;
    logic        bus_req;
    logic [7:0]  bus_read_data;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
               bus_read_data,
        output cmd_ready, wr_ready, rd_valid, rd_data, bus_address, bus_write, bus_wdata,
               bus_req, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
               bus_read_data,
        input  cmd_ready, wr_ready, rd_valid, rd_data, bus_address, bus_write, bus_wdata,
               bus_req, busy
    );
endinterface

// File: rtl/monitor_bus_initiator.sv
// Burst initiator for a byte-wide monitor bus: turns read/write burst commands into
// single-cycle bus accesses, with a 2-entry read FIFO for read-data backpressure.
module monitor_bus_initiator #(
    parameter bit          AUTO_INC  = 1'b1,
    parameter logic [15:0] IDLE_ADDR = 16'h6000
) (
    input logic                     clk,
    input logic                     reset,
    monitor_bus_initiator_if.master mb
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d, addr_next;
    logic [8:0]  count_q, count_d;
    logic        inflight_q, inflight_d;
    logic [7:0]  fifo_q [2];
    logic        head_q;
    logic [1:0]  occ_q;
    logic        push, pop, tail;

    assign addr_next = AUTO_INC ? addr_q + 16'd1 : addr_q;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        count_d        = count_q;
        inflight_d     = 1'b0;
        mb.cmd_ready   = 1'b0;
        mb.wr_ready    = 1'b0;
        mb.bus_address = IDLE_ADDR;
        mb.bus_write   = 1'b0;
        mb.bus_wdata   = 8'h00;
        mb.bus_req     = 1'b0;
        unique case (state_q)
            StIdle: begin
                mb.cmd_ready = 1'b1;
                if (mb.cmd_valid) begin
                    addr_d  = mb.cmd_addr;
                    count_d = {1'b0, mb.cmd_len} + 9'd1;
                    state_d = mb.cmd_write ? StWrite : StRead;
                end
            end
            StWrite: begin
                mb.wr_ready = 1'b1;
                if (mb.wr_valid) begin
                    mb.bus_address = addr_q;
                    mb.bus_write   = 1'b1;
                    mb.bus_wdata   = mb.wr_data;
                    mb.bus_req     = 1'b1;
                    addr_d         = addr_next;
                    count_d        = count_q - 9'd1;
                    if (count_q == 9'd1) state_d = StIdle;
                end
            end
            StRead: begin
                // Issue only if the reply is guaranteed a FIFO slot on capture.
                if ({1'b0, occ_q} + {2'b00, inflight_q} < 3'd2) begin
                    mb.bus_address = addr_q;
                    mb.bus_req     = 1'b1;
                    inflight_d     = 1'b1;
                    addr_d         = addr_next;
                    count_d        = count_q - 9'd1;
                    if (count_q == 9'd1) state_d = StDrain;
                end
            end
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign push       = inflight_q;
    assign pop        = mb.rd_valid & mb.rd_ready;
    assign tail       = head_q ^ occ_q[0];
    assign mb.rd_valid = (occ_q != 2'd0);
    assign mb.rd_data  = mb.rd_valid ? fifo_q[head_q] : 8'h00;
    assign mb.busy     = (state_q != StIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= 16'h0000;
            count_q    <= 9'd0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= 8'h00;
            fifo_q[1]  <= 8'h00;
            head_q     <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            if (push) fifo_q[tail] <= mb.bus_read_data;
            if (pop) head_q <= ~head_q;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: tb/tb_monitor_bus_initiator.sv
// Scoreboard bench: expected bus accesses and read bytes are queued by the stimulus and
// retired by negedge monitors; a second instance covers the fixed-address variant.
module tb_monitor_bus_initiator;

    localparam logic [15:0] IDLE = 16'h6000;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   u_reads;

    monitor_bus_initiator_if u ();
    monitor_bus_initiator_if v ();

    monitor_bus_initiator #(.AUTO_INC(1'b1), .IDLE_ADDR(IDLE)) dut (
        .clk   (clk),
        .reset (reset),
        .mb    (u)
    );

    monitor_bus_initiator #(.AUTO_INC(1'b0), .IDLE_ADDR(IDLE)) dut_fixed (
        .clk   (clk),
        .reset (reset),
        .mb    (v)
    );

    logic [23:0] exp_wr_q[$];
    logic [15:0] exp_rda_q[$];
    logic [7:0]  exp_rdd_q[$];
    logic [15:0] exp_v_rda_q[$];
    logic [7:0]  exp_v_rdd_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] resp(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h51;
    endfunction

    // Responder: data for the address presented in the previous cycle.
    always @(posedge clk) begin
        u.bus_read_data <= resp(u.bus_address);
        v.bus_read_data <= resp(v.bus_address);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (u.bus_req && u.bus_write) begin
                check("wr_expected", exp_wr_q.size() != 0, 1);
                if (exp_wr_q.size() != 0)
                    check("wr_beat", {8'h00, u.bus_address, u.bus_wdata}, {8'h00, exp_wr_q.pop_front()});
            end
            if (u.bus_req && !u.bus_write) begin
                u_reads++;
                check("rd_issue_expected", exp_rda_q.size() != 0, 1);
                if (exp_rda_q.size() != 0)
                    check("rd_issue_addr", {16'h0, u.bus_address}, {16'h0, exp_rda_q.pop_front()});
            end
            if (u.rd_valid && u.rd_ready) begin
                check("rd_data_expected", exp_rdd_q.size() != 0, 1);
                if (exp_rdd_q.size() != 0)
                    check("rd_data", {24'h0, u.rd_data}, {24'h0, exp_rdd_q.pop_front()});
            end
            if (!u.bus_req) check("idle_bus", {15'h0, u.bus_address, u.bus_write}, {15'h0, IDLE, 1'b0});

            if (v.bus_req) begin
                check("fixed_issue_expected", exp_v_rda_q.size() != 0, 1);
                if (exp_v_rda_q.size() != 0)
                    check("fixed_issue", {15'h0, v.bus_address, v.bus_write},
                          {15'h0, exp_v_rda_q.pop_front(), 1'b0});
            end
            if (v.rd_valid && v.rd_ready) begin
                check("fixed_data_expected", exp_v_rdd_q.size() != 0, 1);
                if (exp_v_rdd_q.size() != 0)
                    check("fixed_data", {24'h0, v.rd_data}, {24'h0, exp_v_rdd_q.pop_front()});
            end
            if (!v.bus_req) check("fixed_idle_bus", {15'h0, v.bus_address, v.bus_write}, {15'h0, IDLE, 1'b0});
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_cmd(input logic w, input logic [15:0] a, input logic [7:0] l);
        bit ok = 0;
        u.cmd_valid = 1'b1; u.cmd_write = w; u.cmd_addr = a; u.cmd_len = l;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (u.cmd_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        u.cmd_valid = 1'b0;
        check("cmd_accept", {31'h0, ok}, 1);
    endtask

    task automatic send_wr(input logic [7:0] d);
        bit ok = 0;
        u.wr_valid = 1'b1; u.wr_data = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (u.wr_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        u.wr_valid = 1'b0;
        check("wr_accept", {31'h0, ok}, 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!u.busy && !v.busy && exp_wr_q.size() == 0 && exp_rda_q.size() == 0 &&
                exp_rdd_q.size() == 0 && exp_v_rda_q.size() == 0 && exp_v_rdd_q.size() == 0) begin
                ok = 1; break;
            end
        end
        @(posedge clk); #1;
        check("drain_done", {31'h0, ok}, 1);
    endtask

    initial begin
        int base;
        bit ok;
        total = 0; bad = 0; u_reads = 0;
        reset = 1'b1;
        u.cmd_valid = 0; u.cmd_write = 0; u.cmd_addr = 0; u.cmd_len = 0;
        u.wr_valid = 0; u.wr_data = 0; u.rd_ready = 1;
        v.cmd_valid = 0; v.cmd_write = 0; v.cmd_addr = 0; v.cmd_len = 0;
        v.wr_valid = 0; v.wr_data = 0; v.rd_ready = 1;
        repeat (2) @(negedge clk);
        check("reset_ctrl", {24'h0, u.cmd_ready, u.busy, u.wr_ready, u.rd_valid, u.bus_write,
              u.bus_req, 2'b00}, {24'h0, 8'b1000_0000});
        check("reset_rd_data", {24'h0, u.rd_data}, 0);
        check("reset_bus_addr", {16'h0, u.bus_address}, {16'h0, IDLE});
        check("reset_wdata", {24'h0, u.bus_wdata}, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Single-beat read with exact latency.
        exp_rda_q.push_back(16'hF800); exp_rdd_q.push_back(8'hA9);
        send_cmd(1'b0, 16'hF800, 8'd0);
        @(negedge clk); check("rd1_issue", {15'h0, u.bus_req, u.bus_address}, {15'h0, 1'b1, 16'hF800});
        @(negedge clk); check("rd1_not_yet", {31'h0, u.rd_valid}, 0);
        @(negedge clk); check("rd1_valid", {23'h0, u.rd_valid, u.rd_data}, {23'h0, 1'b1, 8'hA9});
        check("rd1_idle", {31'h0, u.busy}, 0);
        @(posedge clk); #1;
        wait_idle();

        // Burst write with a two-cycle gap after the second byte.
        exp_wr_q.push_back({16'h0010, 8'h11}); exp_wr_q.push_back({16'h0011, 8'h22});
        exp_wr_q.push_back({16'h0012, 8'h33}); exp_wr_q.push_back({16'h0013, 8'h44});
        send_cmd(1'b1, 16'h0010, 8'd3);
        send_wr(8'h11); send_wr(8'h22);
        repeat (2) @(posedge clk); #1;
        send_wr(8'h33); send_wr(8'h44);
        wait_idle();

        // Read backpressure: only two reads may go out before the stall.
        u.rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) exp_rda_q.push_back(16'(i));
        exp_rdd_q.push_back(8'h51); exp_rdd_q.push_back(8'h50);
        exp_rdd_q.push_back(8'h53); exp_rdd_q.push_back(8'h52);
        exp_rdd_q.push_back(8'h55); exp_rdd_q.push_back(8'h54);
        exp_rdd_q.push_back(8'h57); exp_rdd_q.push_back(8'h56);
        base = u_reads;
        send_cmd(1'b0, 16'h0000, 8'd7);
        repeat (6) @(negedge clk);
        check("stall_reads", u_reads - base, 2);
        check("stall_rd_valid", {31'h0, u.rd_valid}, 1);
        @(posedge clk); #1 u.rd_ready = 1'b1;
        wait_idle();

        // Address wrap.
        exp_rda_q.push_back(16'hFFFE); exp_rda_q.push_back(16'hFFFF); exp_rda_q.push_back(16'h0000);
        exp_rdd_q.push_back(8'h50); exp_rdd_q.push_back(8'h51); exp_rdd_q.push_back(8'h51);
        send_cmd(1'b0, 16'hFFFE, 8'd2);
        wait_idle();

        // Fixed-address polling on the AUTO_INC=0 instance.
        for (int i = 0; i < 3; i++) begin
            exp_v_rda_q.push_back(16'h9000); exp_v_rdd_q.push_back(8'hC1);
        end
        v.cmd_valid = 1'b1; v.cmd_write = 1'b0; v.cmd_addr = 16'h9000; v.cmd_len = 8'd2;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (v.cmd_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1 v.cmd_valid = 1'b0;
        check("fixed_cmd_accept", {31'h0, ok}, 1);
        wait_idle();

        // Park a byte in the FIFO, then reset during the third beat of a write burst.
        u.rd_ready = 1'b0;
        exp_rda_q.push_back(16'h1234);
        send_cmd(1'b0, 16'h1234, 8'd0);
        repeat (4) @(negedge clk);
        check("parked_rd_valid", {31'h0, u.rd_valid}, 1);
        @(posedge clk); #1;
        exp_wr_q.push_back({16'h0100, 8'hA0}); exp_wr_q.push_back({16'h0101, 8'hA1});
        send_cmd(1'b1, 16'h0100, 8'd7);
        u.wr_valid = 1'b1; u.wr_data = 8'hA0;
        @(posedge clk); #1 u.wr_data = 8'hA1;
        @(posedge clk); #1 u.wr_data = 8'hA2;
        check("beat3_live", {15'h0, u.bus_write, u.bus_address}, {15'h0, 1'b1, 16'h0102});
        #1 reset = 1'b1;
        #1;
        check("rst_mid_bus", {14'h0, u.bus_write, u.bus_req, u.bus_address}, {14'h0, 2'b00, IDLE});
        check("rst_mid_rd_valid", {31'h0, u.rd_valid}, 0);
        check("rst_mid_cmd_ready", {31'h0, u.cmd_ready}, 1);
        u.wr_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        u.rd_ready = 1'b1;
        @(negedge clk);
        check("post_rst", {29'h0, u.cmd_ready, u.busy, u.rd_valid}, {29'h0, 3'b100});
        @(posedge clk); #1;
        wait_idle();

        check("wr_q_empty", exp_wr_q.size(), 0);
        check("rda_q_empty", exp_rda_q.size(), 0);
        check("rdd_q_empty", exp_rdd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
